mem_arbiter: RTL and testbench

//  Shares the single byte-wide synchronous RAM port between instruction fetch (IF) and the MEM stage.

---
 rtl/mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Byte-serial RAM arbiter between instruction fetch and the MEM stage (MEM has fixed priority).
// Optional MEM_ARB_FETCH_ABORT_EN: a MEM request aborts an in-progress fetch, which restarts afterwards.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  input  logic              if_flush,
  output logic              if_ack,
  output logic [31:0]       if_data,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_size,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_ack,
  output logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din
);

  typedef enum logic [2:0] {IDLE, IF_RD, MEM_RD, MEM_WR, DONE} state_t;

  state_t              state, state_n;
  logic                owner_mem;
  logic [2:0]          k, n, size_n, a_off;
  logic [ADDR_W-1:0]   base;
  logic [31:0]         wdata, rbuf, if_data_q, mem_rdata_q;
  logic                grant_mem, grant_if, k_inc, cap;
  logic                unused_hi;

  assign unused_hi = ^{if_addr[31:ADDR_W], mem_addr[31:ADDR_W]};

  always_comb begin
    case (mem_size)
      2'b00:   size_n = 3'd1;
      2'b01:   size_n = 3'd2;
      default: size_n = 3'd4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    grant_mem = 1'b0;
    grant_if  = 1'b0;
    k_inc     = 1'b0;
    cap       = 1'b0;
    if_ack    = 1'b0;
    mem_ack   = 1'b0;
    ram_wr    = 1'b0;
    ram_dout  = '0;
    a_off     = n - 3'd1;
    case (state)
      IDLE: begin
        if (rdy) begin
          if (mem_req) begin
            grant_mem = 1'b1;
            state_n   = mem_we ? MEM_WR : MEM_RD;
          end else if (if_req && !if_flush) begin
            grant_if = 1'b1;
            state_n  = IF_RD;
          end
        end
      end
      IF_RD, MEM_RD: begin
        // While paused, keep re-presenting the previous byte address so the
        // RAM output lines up with lane k-1 on the first cycle rdy is back.
        if (k == n || (!rdy && k != 3'd0)) a_off = k - 3'd1;
        else                                a_off = k;
        if (rdy) begin
          cap = (k != 3'd0);
          if (state == IF_RD && if_flush) state_n = IDLE;
`ifdef MEM_ARB_FETCH_ABORT_EN
          else if (state == IF_RD && mem_req) begin
            grant_mem = 1'b1;
            state_n   = mem_we ? MEM_WR : MEM_RD;
          end
`endif
          else if (k == n) state_n = DONE;
          else             k_inc   = 1'b1;
        end
      end
      MEM_WR: begin
        a_off    = k;
        ram_wr   = rdy;
        ram_dout = wdata[{k[1:0], 3'b000} +: 8];
        if (rdy) begin
          if (k == n - 3'd1) state_n = DONE;
          else               k_inc   = 1'b1;
        end
      end
      DONE: begin
        if (rdy) begin
          state_n = IDLE;
          if (owner_mem)      mem_ack = 1'b1;
          else if (!if_flush) if_ack  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_mem   <= 1'b0;
      k           <= '0;
      n           <= 3'd1;
      base        <= '0;
      wdata       <= '0;
      rbuf        <= '0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
    end else begin
      if (cap) begin
        for (int unsigned i = 0; i < 4; i++)
          if (k == 3'(i + 1)) rbuf[8*i +: 8] <= ram_din;
      end
      // A grant in the same cycle as a capture (fetch abort) must win.
      if (grant_mem) begin
        owner_mem <= 1'b1;
        base      <= mem_addr[ADDR_W-1:0];
        n         <= size_n;
        wdata     <= mem_wdata;
        k         <= '0;
        rbuf      <= '0;
      end else if (grant_if) begin
        owner_mem <= 1'b0;
        base      <= if_addr[ADDR_W-1:0];
        n         <= 3'd4;
        k         <= '0;
        rbuf      <= '0;
      end else if (k_inc) begin
        k <= k + 3'd1;
      end
      if (if_ack)  if_data_q   <= rbuf;
      if (mem_ack) mem_rdata_q <= rbuf;
    end
  end

  assign ram_a     = base + ADDR_W'(a_off);
  assign if_data   = (state == DONE && !owner_mem) ? rbuf : if_data_q;
  assign mem_rdata = (state == DONE &&  owner_mem) ? rbuf : mem_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a byte-wide synchronous RAM model.
module tb_mem_arbiter;

  localparam int unsigned AW = 17;

  logic          clk = 1'b0;
  logic          rst, rdy;
  logic          if_req, if_flush, if_ack;
  logic [31:0]   if_addr, if_data;
  logic          mem_req, mem_we, mem_ack;
  logic [1:0]    mem_size;
  logic [31:0]   mem_addr, mem_wdata, mem_rdata;
  logic [AW-1:0] ram_a;
  logic          ram_wr;
  logic [7:0]    ram_dout, ram_din;

  logic [7:0]    ram [0:(1<<AW)-1];
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_a;
  logic [7:0]    pre_d;

  int n_cmp = 0;
  int n_err = 0;

  mem_arbiter #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_ack(if_ack), .if_data(if_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ram_a(ram_a), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_we)      ram[pre_a] <= pre_d;
    else if (ram_wr) ram[ram_a] <= ram_dout;
    ram_din <= ram[ram_a];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [7:0] d);
    pre_a = a; pre_d = d; pre_we = 1'b1;
    tick;
    pre_we = 1'b0;
  endtask

  task automatic if_txn(input logic [31:0] addr, output int cyc, output logic [31:0] data);
    if_addr = addr; if_req = 1'b1; cyc = 0;
    do begin tick; cyc++; end while (!if_ack && cyc < 40);
    data = if_data;
    if_req = 1'b0;
  endtask

  task automatic mem_txn(input logic we, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wd, output int cyc, output int wr_cnt,
                         output logic [AW-1:0] first_a, output logic [7:0] first_d,
                         output logic [31:0] rd);
    mem_we = we; mem_size = size; mem_addr = addr; mem_wdata = wd; mem_req = 1'b1;
    cyc = 0; wr_cnt = 0; first_a = '0; first_d = '0;
    do begin
      tick; cyc++;
      if (ram_wr) begin
        if (wr_cnt == 0) begin first_a = ram_a; first_d = ram_dout; end
        wr_cnt++;
      end
    end while (!mem_ack && cyc < 40);
    rd = mem_rdata;
    mem_req = 1'b0;
  endtask

  // Runs with if_req already high; mem_req (load byte 0x20) is raised at tick mem_at (0 = already high).
  task automatic race(input int mem_at, output int tm, output int ti,
                      output logic [31:0] dm, output logic [31:0] di);
    int t;
    t = 0; tm = -1; ti = -1; dm = '0; di = '0;
    while ((tm < 0 || ti < 0) && t < 60) begin
      tick; t++;
      if (t == mem_at) begin
        mem_we = 1'b0; mem_size = 2'b00; mem_addr = 32'h20; mem_req = 1'b1;
      end
      if (mem_ack && tm < 0) begin tm = t; dm = mem_rdata; mem_req = 1'b0; end
      if (if_ack && ti < 0)  begin ti = t; di = if_data;  if_req  = 1'b0; end
    end
  endtask

  int             cyc, wr_cnt, tm, ti, acks;
  logic [AW-1:0]  fa;
  logic [7:0]     fd;
  logic [31:0]    rd, dm, di;

  initial begin
    rst = 1'b1; rdy = 1'b1;
    if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    mem_req = 1'b0; mem_we = 1'b0; mem_size = '0; mem_addr = '0; mem_wdata = '0;
    poke(17'h100, 8'h11); poke(17'h101, 8'h22); poke(17'h102, 8'h33); poke(17'h103, 8'h44);
    poke(17'h200, 8'hA1); poke(17'h201, 8'hB2); poke(17'h202, 8'hC3); poke(17'h203, 8'hD4);
    poke(17'h1FFFF, 8'h80); poke(17'h0, 8'h7F);
    tick;
    check("rst_outputs", {if_ack, mem_ack, ram_wr, 5'b0, ram_dout, 15'b0, ram_a},
          32'h0);
    check("rst_if_data", if_data, 32'h0);
    check("rst_mem_rdata", mem_rdata, 32'h0);
    rst = 1'b0;
    tick;

    // 1: word fetch
    if_txn(32'h100, cyc, rd);
    check("t1_if_latency", cyc, 6);
    check("t1_if_data", rd, 32'h44332211);
    tick;
    check("t1_if_data_hold", if_data, 32'h44332211);

    // 2: byte store
    mem_txn(1'b1, 2'b00, 32'h20, 32'hAABBCCDD, cyc, wr_cnt, fa, fd, rd);
    check("t2_st_latency", cyc, 2);
    check("t2_wr_count", wr_cnt, 1);
    check("t2_wr_addr", 32'(fa), 32'h20);
    check("t2_wr_byte", 32'(fd), 32'hDD);
    tick;
    check("t2_ram_byte", 32'(ram[17'h20]), 32'hDD);

    // 3: simultaneous requests, MEM first
    if_addr = 32'h100; if_req = 1'b1;
    mem_we = 1'b0; mem_size = 2'b00; mem_addr = 32'h20; mem_req = 1'b1;
    race(0, tm, ti, dm, di);
    check("t3_mem_ack_at", tm, 3);
    check("t3_if_ack_at", ti, 10);
    check("t3_mem_rdata", dm, 32'h000000DD);
    check("t3_if_data", di, 32'h44332211);
    tick;

    // 4: half load across the address wrap
    mem_we = 1'b0; mem_size = 2'b01; mem_addr = 32'h1FFFF; mem_req = 1'b1;
    tick;
    check("t4_ram_a_k0", 32'(ram_a), 32'h1FFFF);
    tick;
    check("t4_ram_a_k1", 32'(ram_a), 32'h0);
    cyc = 2;
    do begin tick; cyc++; end while (!mem_ack && cyc < 40);
    check("t4_ld_latency", cyc, 4);
    check("t4_mem_rdata", mem_rdata, 32'h00007F80);
    mem_req = 1'b0;
    tick;

    // word store then word load back
    mem_txn(1'b1, 2'b10, 32'h300, 32'h11223344, cyc, wr_cnt, fa, fd, rd);
    check("ws_latency", cyc, 5);
    check("ws_wr_count", wr_cnt, 4);
    check("ws_first_byte", 32'(fd), 32'h44);
    tick;
    mem_txn(1'b0, 2'b10, 32'h300, 32'h0, cyc, wr_cnt, fa, fd, rd);
    check("wl_latency", cyc, 6);
    check("wl_data", rd, 32'h11223344);
    tick;

    // 5: flush in the 3rd IF_RD cycle, then fetch a new address
    if_addr = 32'h100; if_req = 1'b1;
    tick; tick; tick;
    if_flush = 1'b1; if_req = 1'b0;
    tick;
    check("t5_no_ack", if_ack, 1'b0);
    if_flush = 1'b0;
    if_txn(32'h200, cyc, rd);
    check("t5_refetch_latency", cyc, 6);
    check("t5_refetch_data", rd, 32'hD4C3B2A1);
    tick;

    // 6: MEM request during the 2nd IF_RD cycle
    if_addr = 32'h100; if_req = 1'b1;
    race(2, tm, ti, dm, di);
`ifdef MEM_ARB_FETCH_ABORT_EN
    check("t6_mem_ack_at", tm, 5);
    check("t6_if_ack_at", ti, 12);
`else
    check("t6_if_ack_at", ti, 6);
    check("t6_mem_ack_at", tm, 10);
`endif
    check("t6_mem_rdata", dm, 32'h000000DD);
    check("t6_if_data", di, 32'h44332211);
    tick;

    // 8: rdy low for 3 cycles mid word read
    if_addr = 32'h200; if_req = 1'b1; cyc = 0; acks = 0;
    do begin
      tick; cyc++;
      if (!rdy && if_ack) acks++;
      if (cyc == 3) rdy = 1'b0;
      if (cyc == 6) rdy = 1'b1;
    end while (!if_ack && cyc < 40);
    check("t8_latency", cyc, 9);
    check("t8_data", if_data, 32'hD4C3B2A1);
    check("t8_ack_while_paused", acks, 0);
    if_req = 1'b0;
    tick;

    // 7: reset during a word store
    mem_we = 1'b1; mem_size = 2'b10; mem_addr = 32'h40; mem_wdata = 32'h01020304; mem_req = 1'b1;
    tick; tick;
    rst = 1'b1;
    tick;
    check("t7_ram_wr_after_rst", ram_wr, 1'b0);
    check("t7_if_data_cleared", if_data, 32'h0);
    rst = 1'b0; mem_req = 1'b0; acks = 0;
    if (mem_ack) acks++;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (mem_ack || ram_wr) acks++;
    end
    check("t7_no_ack", acks, 0);
    check("t7_first_byte_written", 32'(ram[17'h40]), 32'h04);
    if_txn(32'h100, cyc, rd);
    check("t7_post_rst_fetch", rd, 32'h44332211);
    check("t7_post_rst_latency", cyc, 6);

    tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
